// File: rtl/i2c_target_fsm.sv
// rtl/i2c_target_fsm.sv - I2C target protocol engine with open-drain SDA, no clock stretching
//
// Oversamples SCL/SDA on clk, detects START / repeated START / STOP, matches a 7-bit address,
// ACKs, hands write bytes to the fabric and serialises read bytes from it.
//
// Parameters
//   TGT_ADDR     7-bit target address
//   SYNC_STAGES  synchroniser depth for scl_i/sda_i (>= 2)
//
// Configuration macro
//   I2C_TGT_GCALL_EN  defined: general call write (8'h00) is ACKed and received, gcall set.
//                     undefined: 8'h00 is treated as a non-matching address, gcall stays 0.
//
// Ports
//   clk       in   system clock, at least 8x SCL
//   rst_n     in   asynchronous active-low reset
//   scl_i     in   SCL pad input (asynchronous)
//   sda_i     in   SDA pad input (asynchronous)
//   sda_oe    out  1 = pull SDA low, 0 = release
//   rx_data   out  last received write byte
//   rx_valid  out  one-clk pulse, rx_data updated
//   tx_data   in   read byte, sampled in the cycle tx_req is high
//   tx_req    out  one-clk pulse, fabric presents tx_data this cycle
//   busy      out  high from address ACK until STOP / repeated START
//   gcall     out  high while the current transfer was addressed by general call

module i2c_target_fsm #(
    parameter logic [6:0] TGT_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       gcall
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers plus one history flop for edge detection.
    // Reset to 1 so an idle (pulled-up) bus produces no events.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SCL must be high on both samples so an SDA change racing an SCL edge is not a condition.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    // ------------------------------------------------------------------
    // Byte assembly and address decode
    // ------------------------------------------------------------------
    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;      // previous 7 bits on receive, remaining 7 bits on transmit
    logic       rw;
    logic       ack_on;     // second half of an ACK slot / master ACK seen in TX_ACK
    logic       gcall_r;

    logic [7:0] in_byte;
    logic       addr_match;
    logic       gcall_match;

    assign in_byte    = {shift, sda_s};
    assign addr_match = (in_byte[7:1] == TGT_ADDR);

`ifdef I2C_TGT_GCALL_EN
    assign gcall_match = (in_byte == 8'h00);
`else
    assign gcall_match = 1'b0;
`endif

    assign gcall = gcall_r;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 7'd0;
            rw       <= 1'b0;
            ack_on   <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            gcall_r  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;

            if (stop_det) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                gcall_r <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
            end else if (start_det) begin
                // Repeated START drops any partial byte without reporting it.
                state   <= ADDR;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                gcall_r <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= in_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw     <= sda_s;
                                ack_on <= 1'b0;
                                if (addr_match || gcall_match) begin
                                    state   <= ADDR_ACK;
                                    gcall_r <= gcall_match;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end

                    // First fall drives the ACK, second fall ends the ACK slot.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                ack_on  <= 1'b0;
                                bit_cnt <= 3'd0;
                                if (rw) begin
                                    // SDA is re-driven with the MSB once tx_data is loaded.
                                    state  <= TX;
                                    tx_req <= 1'b1;
                                end else begin
                                    state  <= RX;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end

                    RX: begin
                        if (scl_rise) begin
                            shift   <= in_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= in_byte;
                                rx_valid <= 1'b1;
                                ack_on   <= 1'b0;
                                state    <= RX_ACK;
                            end
                        end
                    end

                    RX_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                ack_on  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= RX;
                            end
                        end
                    end

                    TX: begin
                        if (tx_req) begin
                            // Fabric presents tx_data in the cycle tx_req is high.
                            shift  <= tx_data[6:0];
                            sda_oe <= ~tx_data[7];
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                // Eight rises seen: release SDA for the master's ACK.
                                sda_oe <= 1'b0;
                                ack_on <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                sda_oe <= ~shift[6];
                                shift  <= {shift[5:0], 1'b0};
                            end
                        end
                    end

                    TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ack_on <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= IGNORE;
                            end
                        end else if (scl_fall && ack_on) begin
                            ack_on  <= 1'b0;
                            bit_cnt <= 3'd0;
                            tx_req  <= 1'b1;
                            state   <= TX;
                        end
                    end

                    IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
